// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and the saturating-increment helper for the sequence detector.
package seq_det_pkg;
    localparam bit MODE_MOORE = 1'b0;
    localparam bit MODE_MEALY = 1'b1;
    localparam int DEF_PAT_W = 5;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 5'b10010;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : (32'd1 << width) - 32'd1;
        return (val >= max_v) ? max_v : val + 32'd1;
    endfunction
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial stream, pattern-load and result signals of the sequence detector.
interface seq_det_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = 8
);
    logic             j;
    logic             j_vld;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             det;
    logic [CNT_W-1:0] match_cnt;

    modport master(output j, j_vld, pat_load, pat_in, input det, match_cnt);
    modport slave(input j, j_vld, pat_load, pat_in, output det, match_cnt);
endinterface

// File: rtl/seq_det_hist.sv
// seq_det_hist: history shift register (newest bit at LSB) and saturating valid-bit count.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift,
    input  logic                         clr,
    input  logic                         j,
    output logic [PAT_W-1:0]             hist,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;

    // clear wins over shift so a pattern load or non-overlap hit restarts matching
    always_comb begin
        hist_d = clr ? '0 : shift ? {hist_q[PAT_W-2:0], j} : hist_q;
        fill_d = clr ? '0 : (shift && fill_q != FW'(PAT_W)) ? fill_q + FW'(1) : fill_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;
endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: runtime-loadable serial pattern detector, Moore/Mealy and overlap selectable.
// Match counter present only when SEQ_DET_MATCH_CNT_EN is defined; otherwise match_cnt is 0.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT),
    parameter bit               MEALY   = MODE_MOORE,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input logic      clk,
    input logic      rst,
    seq_det_if.slave bus
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pat_q, pat_d, hist;
    logic [FW-1:0]    fill;
    logic             hit, clr, det_q, det_d;
    logic             unused_hist_msb;

    // the oldest history bit is shifted out on the matching edge, so compare never needs it
    assign unused_hist_msb = hist[PAT_W-1];

    seq_det_hist #(.PAT_W(PAT_W)) u_hist (
        .clk  (clk),
        .rst  (rst),
        .shift(bus.j_vld),
        .clr  (clr),
        .j    (bus.j),
        .hist (hist),
        .fill (fill)
    );

    always_comb begin
        hit   = bus.j_vld && !bus.pat_load && (fill >= FW'(PAT_W - 1))
                && ({hist[PAT_W-2:0], bus.j} == pat_q);
        clr   = bus.pat_load || (!OVERLAP && hit);
        pat_d = bus.pat_load ? bus.pat_in : pat_q;
        det_d = hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PAT_RST;
            det_q <= 1'b0;
        end else begin
            pat_q <= pat_d;
            det_q <= det_d;
        end
    end

    assign bus.det = MEALY ? (hit && rst) : det_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = hit ? CNT_W'(sat_inc(32'(cnt_q), CNT_W)) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = CNT_W'(0);
`endif
endmodule
